// File: rtl/mips_instruction_fetch_pkg.sv
// Shared definitions for the MIPS instruction fetch unit: defaults, FSM states
// and the {pc, instr} entry carried through the prefetch FIFO.
package mips_instruction_fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEF_RESET_PC     = 32'h0000_0000;
    localparam logic [31:0] DEF_HALT_WORD    = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/mips_fetch_fifo.sv
// Show-ahead prefetch FIFO of {pc, instr} entries; flush empties it and
// overrides any same-cycle push or pop.
module mips_fetch_fifo
    import mips_instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  entries [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = entries[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) entries[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mips_instruction_fetch.sv
// Instruction fetch unit: program memory, PC, issue/return pipeline and FSM,
// delivering instructions through a prefetch FIFO on a valid/ready handshake.
module mips_instruction_fetch
    import mips_instruction_fetch_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] HALT_WORD  = DEF_HALT_WORD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [31:0]           prog_data,
    input  logic                  run,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    input  logic                  instr_ready,
    output logic                  instr_valid,
    output logic [31:0]           instruction,
    output logic [31:0]           instr_pc,
    output logic [31:0]           fetch_pc,
    output logic                  halted
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state, state_nxt;
    logic [31:0]   mem [0:(2**ADDR_WIDTH)-1];
    logic [31:0]   mem_rdata;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic          ret_valid, halt_hit, has_room, issue, push, pop;
    logic          fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  head, ret_entry;

    assign ret_valid = inflight & ~redirect;
    assign halt_hit  = ret_valid & (mem_rdata == HALT_WORD);
    assign push      = ret_valid & ~halt_hit & ~fifo_full;
    assign has_room  = (fifo_count + CW'(inflight)) < CW'(FIFO_DEPTH);
    // Blocking issue on the halt return keeps fetch_pc frozen at halt address + 4.
    assign issue     = run & (state != ST_HALTED) & ~redirect & ~halt_hit & has_room;
    assign pop       = instr_valid & instr_ready & ~redirect;
    assign ret_entry = {inflight_pc, mem_rdata};

    always_comb begin
        state_nxt = state;
        if (redirect) begin
            state_nxt = run ? ST_FETCH : ST_IDLE;
        end else if (halt_hit) begin
            state_nxt = ST_HALTED;
        end else begin
            unique case (state)
                ST_IDLE:   if (run)  state_nxt = ST_FETCH;
                ST_FETCH:  if (!run) state_nxt = ST_IDLE;
                ST_HALTED: state_nxt = ST_HALTED;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (issue) inflight_pc <= fetch_pc;
            if (redirect)   fetch_pc <= redirect_pc & ~32'h3;
            else if (issue) fetch_pc <= fetch_pc + PC_INC;
        end
    end

    // Nonblocking read alongside the write gives old-data on a same-address collision.
    always_ff @(posedge clk) begin
        if (prog_we) mem[prog_addr] <= prog_data;
        if (issue)   mem_rdata <= mem[fetch_pc[ADDR_WIDTH+1:2]];
    end

    mips_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (ret_entry),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign instr_valid = ~fifo_empty;
    assign instruction = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc : '0;
    assign halted      = (state == ST_HALTED);

endmodule

// File: tb/tb_mips_instruction_fetch.sv
// Scoreboard bench for mips_instruction_fetch: expected {pc, word} pairs are
// queued from a reference memory image and checked as the DUT hands them over.
module tb_mips_instruction_fetch;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic        run = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic [31:0] fetch_pc;
    logic        halted;

    logic [31:0] model [256];
    exp_t        sb [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    mips_instruction_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .run         (run),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .instr_pc    (instr_pc),
        .fetch_pc    (fetch_pc),
        .halted      (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: sample the handshake at negedge, then advance past the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (instr_valid && instr_ready && !redirect) begin
            if (sb.size() == 0) begin
                check("spurious_valid", {31'b0, instr_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("instr_pc", instr_pc, e.pc);
                check("instruction", instruction, e.instr);
            end
        end else if (!instr_valid) begin
            check("idle_pc", instr_pc, 32'd0);
            check("idle_instr", instruction, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = model[pc[9:2]];
        sb.push_back(e);
    endtask

    task automatic drain(input int max_cycles);
        instr_ready = 1'b1;
        for (int i = 0; i < max_cycles && sb.size() != 0; i++) tick();
        instr_ready = 1'b0;
        check("drain_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 20 && !halted; i++) tick();
        check({tag, "_halted"}, {31'b0, halted}, 32'd1);
        check({tag, "_halt_valid"}, {31'b0, instr_valid}, 32'd0);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        run         = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        prog_we     = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) model[i] = 32'hC0DE_0000 | 32'(i);
        model[0] = 32'h2008_0001;
        model[1] = 32'h2008_0002;
        model[2] = 32'h2008_0003;
        model[3] = 32'h2008_0004;
        model[4] = HALT;

        #3;
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            prog_we   = 1'b1;
            prog_addr = 8'(i);
            prog_data = model[i];
            @(posedge clk);
            #1;
        end
        prog_we = 1'b0;

        // Reset state and sequential fetch to HALT
        do_reset();
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instruction, 32'd0);
        check("rst_ipc", instr_pc, 32'd0);
        check("rst_fetch_pc", fetch_pc, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
        run = 1'b1;
        instr_ready = 1'b1;
        tick();
        check("lat_edge1", {31'b0, instr_valid}, 32'd0);
        tick();
        check("lat_edge2", {31'b0, instr_valid}, 32'd1);
        drain(20);
        wait_halt("t1");
        check("t1_fetch_pc", fetch_pc, 32'd20);

        // Back-pressure: FIFO fills, fetch_pc freezes
        do_reset();
        for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
        run = 1'b1;
        repeat (8) tick();
        check("t2_fetch_pc", fetch_pc, 32'd16);
        check("t2_valid", {31'b0, instr_valid}, 32'd1);
        check("t2_head_pc", instr_pc, 32'd0);
        check("t2_head_instr", instruction, model[0]);
        drain(20);
        wait_halt("t2");

        // Redirect with three entries queued
        do_reset();
        run = 1'b1;
        repeat (4) tick();
        check("t3_pre_valid", {31'b0, instr_valid}, 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h22;
        tick();
        redirect = 1'b0;
        check("t3_flush_valid", {31'b0, instr_valid}, 32'd0);
        check("t3_fetch_pc", fetch_pc, 32'h20);
        push_exp(32'h20);
        push_exp(32'h24);
        push_exp(32'h28);
        drain(20);
        run = 1'b0;

        // Redirect coincident with a pop and a push
        do_reset();
        run = 1'b1;
        instr_ready = 1'b1;
        tick();
        tick();
        check("t4_pre_valid", {31'b0, instr_valid}, 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        check("t4_flush_valid", {31'b0, instr_valid}, 32'd0);
        push_exp(32'h40);
        push_exp(32'h44);
        push_exp(32'h48);
        drain(20);
        run = 1'b0;

        // Address wrap at the top of memory
        do_reset();
        redirect = 1'b1;
        redirect_pc = 32'h3FC;
        run = 1'b1;
        tick();
        redirect = 1'b0;
        check("t5_fetch_pc", fetch_pc, 32'h3FC);
        push_exp(32'h3FC);
        push_exp(32'h400);
        drain(20);
        run = 1'b0;

        // Asynchronous reset between edges, then refetch with memory retained
        do_reset();
        run = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t6_valid", {31'b0, instr_valid}, 32'd0);
        check("t6_instr", instruction, 32'd0);
        check("t6_ipc", instr_pc, 32'd0);
        check("t6_fetch_pc", fetch_pc, 32'd0);
        check("t6_halted", {31'b0, halted}, 32'd0);
        run = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
        run = 1'b1;
        drain(20);
        wait_halt("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
